// File: rtl/rfphoenix_thread_ready.sv
// rfphoenix_thread_ready: per-thread readiness tracker for the round-robin
// thread selector. Each hardware thread has a small state machine
// (OFF / READY / INFLIGHT / WAIT) and a wait counter. Only READY threads are
// requested, and a thread granted or halted this cycle is masked at once.
// This keeps a thread to at most one instruction in flight.
module rfphoenix_thread_ready #(
  parameter int                  NTHREADS  = 8,
  parameter logic [NTHREADS-1:0] BOOT_MASK = 'h01,
  parameter int                  WCW       = 8,
  localparam int                 TIDW      = $clog2(NTHREADS),
  localparam int                 NAW       = $clog2(NTHREADS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                launch_v,
  input  logic [TIDW-1:0]     launch_tid,
  input  logic                halt_v,
  input  logic [TIDW-1:0]     halt_tid,
  input  logic                sel_v,
  input  logic [TIDW-1:0]     sel_tid,
  input  logic                ret_v,
  input  logic [TIDW-1:0]     ret_tid,
  input  logic                ret_wait,
  input  logic [WCW-1:0]      ret_cycles,
  input  logic                wake_v,
  input  logic [TIDW-1:0]     wake_tid,
  output logic [NTHREADS-1:0] ready,
  output logic [NAW-1:0]      nactive,
  output logic                err
);

  typedef enum logic [1:0] {
    ST_OFF      = 2'd0,
    ST_READY    = 2'd1,
    ST_INFLIGHT = 2'd2,
    ST_WAIT     = 2'd3
  } state_e;

  localparam int TIDN = 1 << TIDW;

  // Bit i set when thread id i names a real thread.
  localparam logic [TIDN-1:0] TID_OK = {TIDN{1'b1}} >> (TIDN - NTHREADS);

  function automatic logic [NAW-1:0] count_boot(input logic [NTHREADS-1:0] m);
    logic [NAW-1:0] n;
    n = '0;
    for (int i = 0; i < NTHREADS; i++) begin
      if (m[i]) n = n + NAW'(1);
    end
    return n;
  endfunction

  localparam logic [NAW-1:0] BOOT_CNT = count_boot(BOOT_MASK);

  state_e         state_q [NTHREADS];
  state_e         state_d [NTHREADS];
  logic [WCW-1:0] cnt_q   [NTHREADS];
  logic [WCW-1:0] cnt_d   [NTHREADS];
  logic           err_q, err_d;
  logic [NAW-1:0] nactive_q, nactive_d;

  logic [NTHREADS-1:0] launch_hit, halt_hit, sel_hit, ret_hit, wake_hit;
  logic                tid_err;

  // Decode each event into a per-thread hit vector and flag ids beyond the last thread.
  always_comb begin
    for (int t = 0; t < NTHREADS; t++) begin
      launch_hit[t] = launch_v && (launch_tid == TIDW'(t));
      halt_hit[t]   = halt_v   && (halt_tid   == TIDW'(t));
      sel_hit[t]    = sel_v    && (sel_tid    == TIDW'(t));
      ret_hit[t]    = ret_v    && (ret_tid    == TIDW'(t));
      wake_hit[t]   = wake_v   && (wake_tid   == TIDW'(t));
    end
    tid_err = (launch_v && !TID_OK[launch_tid]) ||
              (halt_v   && !TID_OK[halt_tid])   ||
              (sel_v    && !TID_OK[sel_tid])    ||
              (ret_v    && !TID_OK[ret_tid])    ||
              (wake_v   && !TID_OK[wake_tid]);
  end

  // Per-thread next state: halt overrides everything; illegal events are dropped and raise err.
  always_comb begin
    err_d = err_q | tid_err;
    for (int t = 0; t < NTHREADS; t++) begin
      state_d[t] = state_q[t];
      cnt_d[t]   = cnt_q[t];
      if (halt_hit[t]) begin
        state_d[t] = ST_OFF;
        cnt_d[t]   = '0;
      end else begin
        if (sel_hit[t]    && state_q[t] != ST_READY)    err_d = 1'b1;
        if (ret_hit[t]    && state_q[t] != ST_INFLIGHT) err_d = 1'b1;
        if (launch_hit[t] && state_q[t] != ST_OFF)      err_d = 1'b1;
        case (state_q[t])
          ST_INFLIGHT: begin
            if (ret_hit[t]) begin
              if (ret_wait) begin
                state_d[t] = ST_WAIT;
                cnt_d[t]   = ret_cycles;
              end else begin
                state_d[t] = ST_READY;
              end
            end
          end
          ST_READY: begin
            if (sel_hit[t]) state_d[t] = ST_INFLIGHT;
          end
          ST_WAIT: begin
            if (wake_hit[t]) begin
              state_d[t] = ST_READY;
              cnt_d[t]   = '0;
            end else if (cnt_q[t] > WCW'(1)) begin
              cnt_d[t] = cnt_q[t] - WCW'(1);
            end else if (cnt_q[t] == WCW'(1)) begin
              state_d[t] = ST_READY;
              cnt_d[t]   = '0;
            end
          end
          default: begin
            if (launch_hit[t]) state_d[t] = ST_READY;
          end
        endcase
      end
    end
  end

  // Population count of live threads, registered so it trails state by one cycle.
  always_comb begin
    nactive_d = '0;
    for (int t = 0; t < NTHREADS; t++) begin
      if (state_q[t] != ST_OFF) nactive_d = nactive_d + NAW'(1);
    end
  end

  // Request vector: READY threads, minus any granted or halted in this very cycle.
  always_comb begin
    for (int t = 0; t < NTHREADS; t++) begin
      ready[t] = (state_q[t] == ST_READY) && !sel_hit[t] && !halt_hit[t];
    end
  end

  // State registers; reset drops all in-flight and wait status and reboots BOOT_MASK threads.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < NTHREADS; t++) begin
        state_q[t] <= BOOT_MASK[t] ? ST_READY : ST_OFF;
        cnt_q[t]   <= '0;
      end
      err_q     <= 1'b0;
      nactive_q <= BOOT_CNT;
    end else begin
      for (int t = 0; t < NTHREADS; t++) begin
        state_q[t] <= state_d[t];
        cnt_q[t]   <= cnt_d[t];
      end
      err_q     <= err_d;
      nactive_q <= nactive_d;
    end
  end

  assign nactive = nactive_q;
  assign err     = err_q;

endmodule
